// File: rtl/rst_pulse_gen.sv
// Reset pulse generator: emits a fixed-width reset pulse on request (and optionally at
// power-on), then enforces a recovery hold-off before another pulse may start.
// One request may be queued while busy; a requested sequence ends with a one-cycle ack.
module rst_pulse_gen #(
    parameter int unsigned PULSE_CYCLES   = 128,
    parameter int unsigned HOLDOFF_CYCLES = 64,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter bit          POR_EN         = 1'b1
) (
    input  logic clk,
    input  logic rst_i,
    input  logic req_i,
    output logic rst_o,
    output logic rst_n_o,
    output logic busy_o,
    output logic ack_o
);

    localparam logic [63:0] CntMax = (64'd1 << CNT_WIDTH) - 64'd1;

    // Both durations must fit the shared counter; reject bad configurations at elaboration.
    if (PULSE_CYCLES == 0 || 64'(PULSE_CYCLES) > CntMax) begin : g_bad_pulse
        $error("rst_pulse_gen: PULSE_CYCLES out of range for CNT_WIDTH");
    end
    if (HOLDOFF_CYCLES == 0 || 64'(HOLDOFF_CYCLES) > CntMax) begin : g_bad_holdoff
        $error("rst_pulse_gen: HOLDOFF_CYCLES out of range for CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] PulseLast = CNT_WIDTH'(PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HoldLast  = CNT_WIDTH'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StHold
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   from_req_q, from_req_d;
    // Set while rst_i is sampled high; the first edge after release then acts as the
    // pulse entry edge, so a POR pulse spans the whole reset plus PULSE_CYCLES.
    logic                   in_rst_q, in_rst_d;
    logic                   rst_q, rst_d;
    logic                   rst_n_q, rst_n_d;
    logic                   busy_q, busy_d;
    logic                   ack_q, ack_d;
    logic                   req_any;

    assign req_any = pend_q | req_i;

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_WIDTH'(1);
        pend_d     = pend_q;
        from_req_d = from_req_q;
        in_rst_d   = 1'b0;
        rst_d      = 1'b0;
        busy_d     = 1'b0;
        ack_d      = 1'b0;

        if (rst_i) begin
            in_rst_d   = 1'b1;
            cnt_d      = '0;
            pend_d     = 1'b0;
            from_req_d = 1'b0;
            rst_d      = 1'b1;
            if (POR_EN) begin
                state_d = StAssert;
                busy_d  = 1'b1;
            end else begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (req_i) begin
                        state_d    = StAssert;
                        from_req_d = 1'b1;
                        rst_d      = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
                StAssert: begin
                    rst_d  = 1'b1;
                    busy_d = 1'b1;
                    pend_d = req_any;
                    if (in_rst_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == PulseLast) begin
                        state_d = StHold;
                        cnt_d   = '0;
                        rst_d   = 1'b0;
                    end
                end
                StHold: begin
                    busy_d = 1'b1;
                    pend_d = req_any;
                    if (cnt_q == HoldLast) begin
                        ack_d = from_req_q;
                        cnt_d = '0;
                        if (req_any) begin
                            // Queued request starts immediately; ack and rise share this edge.
                            state_d    = StAssert;
                            pend_d     = 1'b0;
                            from_req_d = 1'b1;
                            rst_d      = 1'b1;
                        end else begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            endcase
        end

        rst_n_d = ~rst_d;
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        pend_q     <= pend_d;
        from_req_q <= from_req_d;
        in_rst_q   <= in_rst_d;
        rst_q      <= rst_d;
        rst_n_q    <= rst_n_d;
        busy_q     <= busy_d;
        ack_q      <= ack_d;
    end

    assign rst_o   = rst_q;
    assign rst_n_o = rst_n_q;
    assign busy_o  = busy_q;
    assign ack_o   = ack_q;

endmodule

// File: tb/tb_rst_pulse_gen.sv
// Bench for rst_pulse_gen: three instances (4/2 no-POR, 4/2 POR, defaults no-POR).
// Expected high-intervals of rst_o/busy_o/ack_o are queued when stimulus is issued;
// a monitor measures every interval and matches it against the queue.
module tb_rst_pulse_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v;
    logic [2:0] req_v;
    logic [2:0] rst_o_v;
    logic [2:0] rst_n_v;
    logic [2:0] busy_v;
    logic [2:0] ack_v;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int dut;
        int kind;
        int start;
        int len;
    } ev_t;

    ev_t sb[$];

    // Index 0: 4/2 no POR
    rst_pulse_gen #(
        .PULSE_CYCLES  (4),
        .HOLDOFF_CYCLES(2),
        .CNT_WIDTH     (16),
        .POR_EN        (1'b0)
    ) dut_a (
        .clk    (clk),
        .rst_i  (rst_v[0]),
        .req_i  (req_v[0]),
        .rst_o  (rst_o_v[0]),
        .rst_n_o(rst_n_v[0]),
        .busy_o (busy_v[0]),
        .ack_o  (ack_v[0])
    );

    // Index 1: 4/2 with POR
    rst_pulse_gen #(
        .PULSE_CYCLES  (4),
        .HOLDOFF_CYCLES(2),
        .CNT_WIDTH     (16),
        .POR_EN        (1'b1)
    ) dut_p (
        .clk    (clk),
        .rst_i  (rst_v[1]),
        .req_i  (req_v[1]),
        .rst_o  (rst_o_v[1]),
        .rst_n_o(rst_n_v[1]),
        .busy_o (busy_v[1]),
        .ack_o  (ack_v[1])
    );

    // Index 2: default durations, no POR
    rst_pulse_gen #(
        .POR_EN(1'b0)
    ) dut_d (
        .clk    (clk),
        .rst_i  (rst_v[2]),
        .req_i  (req_v[2]),
        .rst_o  (rst_o_v[2]),
        .rst_n_o(rst_n_v[2]),
        .busy_o (busy_v[2]),
        .ack_o  (ack_v[2])
    );

    function automatic string kind_name(int k);
        case (k)
            0:       return "rst_o pulse";
            1:       return "busy_o window";
            default: return "ack_o pulse";
        endcase
    endfunction

    function automatic logic sig_at(int d, int k);
        case (k)
            0:       return rst_o_v[d];
            1:       return busy_v[d];
            default: return ack_v[d];
        endcase
    endfunction

    task automatic push(input int d, input int k, input int s, input int l);
        ev_t e;
        e.dut   = d;
        e.kind  = k;
        e.start = s;
        e.len   = l;
        sb.push_back(e);
    endtask

    task automatic sb_check(input int d, input int k, input int s, input int l);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].dut == d && sb[i].kind == k) idx = i;
        end
        tests++;
        if (idx < 0) begin
            fails++;
            $display("FAIL %s dut%0d: got start %0d len %0d, required none", kind_name(k), d, s, l);
        end else begin
            if (sb[idx].start != s || sb[idx].len != l) begin
                fails++;
                $display("FAIL %s dut%0d: got start %0d len %0d, required start %0d len %0d",
                         kind_name(k), d, s, l, sb[idx].start, sb[idx].len);
            end
            sb.delete(idx);
        end
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: measures high intervals of each output and checks rst_n_o every cycle.
    initial begin
        bit prev [3][3];
        int rise [3][3];
        bit cur;
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 3; k++) begin
                prev[d][k] = 1'b0;
                rise[d][k] = 0;
            end
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                for (int d = 0; d < 3; d++) begin
                    tests++;
                    if (rst_n_v[d] !== ~rst_o_v[d]) begin
                        fails++;
                        $display("FAIL rst_n_o dut%0d cyc %0d: got %b, required %b",
                                 d, cyc, rst_n_v[d], ~rst_o_v[d]);
                    end
                    for (int k = 0; k < 3; k++) begin
                        cur = (sig_at(d, k) === 1'b1);
                        if (cur && !prev[d][k]) rise[d][k] = cyc;
                        else if (!cur && prev[d][k]) sb_check(d, k, rise[d][k], cyc - rise[d][k]);
                        prev[d][k] = cur;
                    end
                end
            end
        end
    end

    // Stimulus: inputs change on negedges, cycle n means the state after posedge n.
    initial begin
        rst_v = 3'b111;
        req_v = 3'b000;
        push(0, 0, 1, 3);
        push(1, 0, 1, 7);
        push(1, 1, 1, 9);
        push(2, 0, 1, 3);

        wait_cyc(1);
        chk("reset rst_o", rst_o_v, 3'b111);
        chk("reset rst_n_o", rst_n_v, 3'b000);
        chk("reset busy_o", busy_v, 3'b010);
        chk("reset ack_o", ack_v, 3'b000);

        wait_cyc(3);
        rst_v = 3'b000;

        // Single requests on the 4/2 and default instances.
        wait_cyc(10);
        req_v[0] = 1'b1;
        req_v[2] = 1'b1;
        push(0, 0, 11, 4);
        push(0, 1, 11, 6);
        push(0, 2, 17, 1);
        push(2, 0, 11, 128);
        push(2, 1, 11, 192);
        push(2, 2, 203, 1);
        wait_cyc(11);
        req_v[0] = 1'b0;
        req_v[2] = 1'b0;

        // Requested sequence on the POR instance does ack.
        wait_cyc(20);
        req_v[1] = 1'b1;
        push(1, 0, 21, 4);
        push(1, 1, 21, 6);
        push(1, 2, 27, 1);
        wait_cyc(21);
        req_v[1] = 1'b0;

        // Requests during ASSERT merge into one queued sequence.
        wait_cyc(30);
        req_v[0] = 1'b1;
        push(0, 0, 31, 4);
        push(0, 0, 37, 4);
        push(0, 1, 31, 12);
        push(0, 2, 37, 1);
        push(0, 2, 43, 1);
        wait_cyc(31);
        req_v[0] = 1'b0;
        wait_cyc(32);
        req_v[0] = 1'b1;
        wait_cyc(34);
        req_v[0] = 1'b0;

        // Re-reset of the POR instance: 2 reset cycles + 4, no ack.
        wait_cyc(40);
        rst_v[1] = 1'b1;
        push(1, 0, 41, 6);
        push(1, 1, 41, 8);
        wait_cyc(42);
        rst_v[1] = 1'b0;

        // Request during HOLD is queued.
        wait_cyc(50);
        req_v[0] = 1'b1;
        push(0, 0, 51, 4);
        push(0, 0, 57, 4);
        push(0, 1, 51, 12);
        push(0, 2, 57, 1);
        push(0, 2, 63, 1);
        wait_cyc(51);
        req_v[0] = 1'b0;
        wait_cyc(55);
        req_v[0] = 1'b1;
        wait_cyc(56);
        req_v[0] = 1'b0;

        // Request held for 20 cycles: back-to-back pulses every 6 cycles.
        wait_cyc(70);
        req_v[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(0, 0, 71 + 6 * i, 4);
            push(0, 2, 77 + 6 * i, 1);
        end
        push(0, 1, 71, 30);
        wait_cyc(90);
        req_v[0] = 1'b0;

        // Reset mid-ASSERT with a pending request: pend dropped, no ack.
        wait_cyc(110);
        req_v[0] = 1'b1;
        push(0, 0, 111, 5);
        push(0, 1, 111, 3);
        wait_cyc(111);
        req_v[0] = 1'b0;
        wait_cyc(112);
        req_v[0] = 1'b1;
        wait_cyc(113);
        req_v[0] = 1'b0;
        rst_v[0] = 1'b1;
        wait_cyc(115);
        rst_v[0] = 1'b0;

        wait_cyc(230);
        chk("final rst_o", rst_o_v, 3'b000);
        chk("final rst_n_o", rst_n_v, 3'b111);
        chk("final busy_o", busy_v, 3'b000);
        chk("final ack_o", ack_v, 3'b000);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            foreach (sb[i])
                $display("FAIL %s dut%0d missing: got nothing, required start %0d len %0d",
                         kind_name(sb[i].kind), sb[i].dut, sb[i].start, sb[i].len);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
